// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and shift_en-paced serial stream.
// First bit appears the cycle after accept; a new word is taken on the last-bit cycle for gapless framing.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]  bit_cnt;
    logic           last_bit;
    logic           accept;

    assign last_bit   = (bit_cnt == LAST);
    assign load_ready = !rst && ((state == IDLE) || (last_bit && shift_en));
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            state   <= SHIFT;
            shreg   <= load_data;
            bit_cnt <= '0;
        end else if (state == SHIFT && shift_en) begin
            if (last_bit) begin
                // Clearing here keeps ser_out low while idle.
                state   <= IDLE;
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
                if (MSB_FIRST != 0)
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                else
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    assign ser_out     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign ser_valid   = (state == SHIFT);
    assign busy        = ser_valid;
    assign frame_start = ser_valid && (bit_cnt == '0);
    assign frame_end   = ser_valid && last_bit;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus, each with its own expected-bit queue.
module tb_piso_serializer;
    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       shift_en;

    logic m_rdy, m_out, m_vld, m_fs, m_fe, m_busy;
    logic l_rdy, l_out, l_vld, l_fs, l_fe, l_busy;

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } exp_t;

    exp_t qm[$];
    exp_t ql[$];
    int   total = 0;
    int   bad   = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(m_rdy), .shift_en(shift_en), .ser_out(m_out), .ser_valid(m_vld),
        .frame_start(m_fs), .frame_end(m_fe), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(l_rdy), .shift_en(shift_en), .ser_out(l_out), .ser_valid(l_vld),
        .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic mon(input string t, input exp_t e, input bit v,
                       input logic d_out, input logic d_vld, input logic d_busy,
                       input logic d_fs, input logic d_fe, input logic d_rdy);
        check({t, "_ser_valid"},   d_vld,  v);
        check({t, "_busy"},        d_busy, v);
        check({t, "_ser_out"},     d_out,  v && e.b);
        check({t, "_frame_start"}, d_fs,   v && e.fs);
        check({t, "_frame_end"},   d_fe,   v && e.fe);
        check({t, "_load_ready"},  d_rdy,  !rst && (!v || (e.fe && shift_en)));
    endtask

    // Monitor: compares every cycle; a bit is consumed when the receiver would sample it.
    always @(negedge clk) begin
        exp_t em, el;
        bit   vm, vl;
        vm = (qm.size() > 0);
        vl = (ql.size() > 0);
        em = vm ? qm[0] : '0;
        el = vl ? ql[0] : '0;
        mon("msb", em, vm, m_out, m_vld, m_busy, m_fs, m_fe, m_rdy);
        mon("lsb", el, vl, l_out, l_vld, l_busy, l_fs, l_fe, l_rdy);
        if (vm && shift_en) void'(qm.pop_front());
        if (vl && shift_en) void'(ql.pop_front());
    end

    task automatic push(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            qm.push_back({w[7-i], i == 0, i == 7});
            ql.push_back({w[i],   i == 0, i == 7});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after accept with load_valid still high.
    task automatic send(input logic [7:0] w);
        bit ok;
        ok = 0;
        load_valid = 1'b1;
        load_data  = w;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_rdy) begin
                @(posedge clk);
                push(w);
                #1;
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout word=%h: got no accept expected accept", w);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (qm.size() == 0 && ql.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_timeout: got %0d bits pending expected 0", qm.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        shift_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step(1);

        // Single words, continuous shift
        send(8'hA5); load_valid = 1'b0; drain();
        send(8'h01); load_valid = 1'b0; drain();

        // Back-to-back with load_valid held
        send(8'hF0); send(8'h0F); load_valid = 1'b0; drain();

        // Stall after bit 2
        send(8'hC3); load_valid = 1'b0;
        step(1);
        shift_en = 1'b0;
        step(3);
        shift_en = 1'b1;
        drain();

        // Reset during bit 4, with a load attempt that must lose to reset
        send(8'hFF); load_valid = 1'b0;
        step(3);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        @(posedge clk);
        qm.delete();
        ql.delete();
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        step(2);
        send(8'h81); load_valid = 1'b0; drain();

        // Backpressure: next word waits mid-word and through a last-bit stall
        send(8'h3C);
        load_data = 8'h96;
        step(7);
        shift_en = 1'b0;
        step(2);
        shift_en = 1'b1;
        send(8'h96); load_valid = 1'b0; drain();

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter for a single-bit serial link.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per enabled clock.
- Drives a downstream flip-flop capture chain (SIPO receiver) that samples ser_out when ser_valid is high.
- Provides frame markers and supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to transmit.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  advance the serial stream this cycle; low = stall/hold.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a valid data bit.
- frame_start  output  1  ser_out is the first bit of a word.
- frame_end  output  1  ser_out is the last bit of a word.
- busy  output  1  word in flight (same as ser_valid).

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, shift register=0, bit_cnt=0.
  - Outputs: ser_out=0, ser_valid=0, frame_start=0, frame_end=0, busy=0.
  - load_ready is forced to 0 in any cycle where rst is high.
  - Reset mid-word discards the word; no partial frame resumes.
- States: IDLE, SHIFT.
  - bit_cnt is $clog2(WIDTH) bits wide.
  - The shift register holds the remaining bits.
- load_ready (combinational, rst low):
  - 1 in IDLE.
  - 1 in SHIFT only when bit_cnt==WIDTH-1 and shift_en==1.
  - 0 otherwise.
- Accept: load_valid && load_ready at a rising edge.
  - Shift register loads load_data, bit_cnt=0, state=SHIFT.
  - Latency: word accepted at edge N; its first bit is on ser_out from edge N to N+1.
  - load_data is ignored when not accepted.
- IDLE: ser_valid=0, ser_out=0; state changes only on accept.
- SHIFT:
  - ser_valid=1.
  - ser_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. Driven directly from the register, no combinational path from inputs.
  - shift_en=0: state, shreg and bit_cnt hold; outputs are stable. A stall may last indefinitely.
  - shift_en=1 and bit_cnt<WIDTH-1: shift toward the output end (zero-fill) and increment bit_cnt.
  - shift_en=1 and bit_cnt==WIDTH-1: if accept occurs the same cycle, load the new word, set bit_cnt=0 and stay in SHIFT (gapless). Otherwise go to IDLE.
- frame_start = ser_valid && bit_cnt==0.
- frame_end = ser_valid && bit_cnt==WIDTH-1.
- Both markers hold through stalls. frame_start and frame_end are never both high.
- Each bit stays on ser_out for exactly one shift_en-high cycle. The receiver samples on edges where ser_valid && shift_en.
- Simultaneous rst and load_valid: rst wins; nothing is accepted.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1:
  - Stimulus: load 8'hA5 with shift_en held 1.
  - Response: ser_out over 8 cycles = 1,0,1,0,0,1,0,1.
  - frame_start on cycle 1 and frame_end on cycle 8. ser_valid is high for exactly 8 cycles, then IDLE with load_ready=1.
- MSB_FIRST=0:
  - Stimulus: load 8'hA5.
  - Response: ser_out = 1,0,1,0,0,1,0,1 (LSB first; the pattern equals the bit-reverse of A5 = A5).
  - Stimulus: load 8'h01.
  - Response: 1,0,0,0,0,0,0,0.
- Back-to-back:
  - Stimulus: load_valid held high with words 8'hF0 then 8'h0F.
  - Response: 16 consecutive ser_valid cycles, stream 11110000 00001111.
  - load_ready pulses high only on the 8th bit. frame_start is on cycles 1 and 9.
- Stall:
  - Stimulus: load 8'hC3; drop shift_en for 3 cycles after bit 2.
  - Response: ser_out, ser_valid and bit position are frozen during the stall. Total ser_valid duration is 11 cycles. The sampled bit stream is still 11000011.
- Reset mid-word:
  - Stimulus: assert rst for 1 cycle during bit 4 of 8'hFF.
  - Response: next cycle ser_valid=0 and ser_out=0. load_ready is 0 during rst and 1 afterwards.
  - A subsequent load of 8'h81 transmits cleanly as 10000001.
- Backpressure:
  - Stimulus: load_valid high mid-word (bits 2-7).
  - Response: no accept while load_ready=0. The word is accepted only at the last-bit cycle.
